// File: rtl/reg_loader_pkg.sv
// reg_loader_pkg: shared state type and index constants for reg_loader.
// The CHECK state exists only when REG_LOADER_CHECK_EN is defined.
package reg_loader_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int REG_IDX_W = 5;
    localparam int LAST_IDX  = 31;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef REG_LOADER_CHECK_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/reg_loader.sv
// reg_loader: streams one beat per register x1..x31 into a register file.
// Optional XOR readback verify of the loaded values under REG_LOADER_CHECK_EN.
module reg_loader
    import reg_loader_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_data,
    output logic                 wen,
    output logic [REG_IDX_W-1:0] waddr,
    output logic [XLEN-1:0]      wdata
`ifdef REG_LOADER_CHECK_EN
    ,
    output logic [REG_IDX_W-1:0] raddr,
    input  logic [XLEN-1:0]      rdata,
    output logic                 mismatch
`endif
);
    localparam logic [REG_IDX_W-1:0] LAST = REG_IDX_W'(NREGS - 1);
`ifdef REG_LOADER_CHECK_EN
    localparam state_t AFTER_LOAD = S_CHECK;
`else
    localparam state_t AFTER_LOAD = S_DONE;
`endif
    state_t               state, state_nx;
    logic [REG_IDX_W-1:0] idx;
    logic                 beat, in_check, wen_q;
    logic [REG_IDX_W-1:0] waddr_q;
    logic [XLEN-1:0]      wdata_q;

`ifdef REG_LOADER_CHECK_EN
    assign in_check = state == S_CHECK;
`else
    assign in_check = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = rst_n && state == S_LOAD;
        busy     = rst_n && (state == S_LOAD || in_check);
        done     = rst_n && state == S_DONE;
        beat     = in_valid && in_ready;
        case (state)
            S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = (beat && idx == LAST) ? AFTER_LOAD : S_LOAD;
`ifdef REG_LOADER_CHECK_EN
            S_CHECK: state_nx = (idx == LAST) ? S_DONE : S_CHECK;
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // idx walks 1..LAST during LOAD, then again during the CHECK sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= REG_IDX_W'(1);
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= beat;
            if (beat) begin
                waddr_q <= idx;
                wdata_q <= in_data;
            end
            if (state == S_IDLE && start) idx <= REG_IDX_W'(1);
            else if (beat || in_check)    idx <= (idx == LAST) ? REG_IDX_W'(1) : idx + 1'b1;
        end
    end

    assign wen   = rst_n && wen_q;
    assign waddr = rst_n ? waddr_q : '0;
    assign wdata = rst_n ? wdata_q : '0;

`ifdef REG_LOADER_CHECK_EN
    logic [XLEN-1:0] load_sum, read_sum;
    logic            mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_IDLE && start)) begin
            load_sum <= '0;
            read_sum <= '0;
            mis_q    <= 1'b0;
        end else begin
            if (beat) load_sum <= load_sum ^ in_data;
            if (in_check) begin
                read_sum <= read_sum ^ rdata;
                if (idx == LAST) mis_q <= load_sum != (read_sum ^ rdata);
            end
        end
    end

    assign raddr    = (rst_n && in_check) ? idx : '0;
    assign mismatch = rst_n && mis_q;
`endif
endmodule

// File: tb/tb_reg_loader.sv
// tb_reg_loader: randomized bench for reg_loader against a cycle-count model.
// Readback checks are compiled in with REG_LOADER_CHECK_EN.
module tb_reg_loader;
    import reg_loader_pkg::*;
    localparam int XLEN = 64;
`ifdef REG_LOADER_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, poke = 1'b0;
    logic [XLEN-1:0] in_data = '0;
    logic busy, done, in_ready, wen;
    logic [REG_IDX_W-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rf [32];
    logic exp_mis = 1'b0;
    int vectors = 0, miscompares = 0;
`ifdef REG_LOADER_CHECK_EN
    logic [REG_IDX_W-1:0] raddr;
    logic [XLEN-1:0] rdata;
    logic mismatch;
    assign rdata = rf[raddr];
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen) rf[waddr] <= wdata;
        if (poke) rf[7] <= 64'hDEAD;
    end

    reg_loader #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wen(wen), .waddr(waddr), .wdata(wdata)
`ifdef REG_LOADER_CHECK_EN
        , .raddr(raddr), .rdata(rdata), .mismatch(mismatch)
`endif
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
`ifdef REG_LOADER_CHECK_EN
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_mismatch"}, mismatch, 0);
`endif
    endtask

    // mode: 0 no bubbles, 1 alternating valid, 2 random, 3 start during load, 4 reset after 10 beats
    task automatic run_seq(input int mode, input bit corrupt);
        logic [XLEN-1:0] data [32];
        logic [XLEN-1:0] pw_data = '0;
        int n = 0, last = -1, fin = -1, pw_idx = 0;
        bit pw = 0, v, rdy, beat, finished = 0;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c < 300; c++) begin
            rdy = n < 31;
            v = mode == 1 ? c % 2 == 1 : mode == 2 ? $urandom_range(0, 2) != 0 : 1'b1;
            in_valid = v;
            in_data = mode == 2 ? {$urandom, $urandom} : 64'(n + 1) * 64'h1111;
            start = (mode == 3 && (n == 10 || c == fin)) || (mode == 2 && $urandom_range(0, 7) == 0);
            poke = corrupt && last > 0 && c == last + 2;
            if (mode == 4 && n == 10) begin
                rst_n = 1'b0;
                start = 1'b1;
                @(negedge clk);
                check_all_zero("rst_mid");
                exp_mis = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                check_all_zero("post_rst");
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            beat = rdy && v;
            if (c == 1) exp_mis = 1'b0;
            if (c == fin && CHK == 1) exp_mis = corrupt && data[7] != 64'hDEAD;
            check("in_ready", in_ready, rdy);
            check("busy", busy, rdy || (last > 0 && c < fin));
            check("done", done, c == fin);
            check("wen", wen, pw);
            if (pw) begin
                check("waddr", waddr, 64'(pw_idx));
                check("wdata", wdata, pw_data);
            end
`ifdef REG_LOADER_CHECK_EN
            check("raddr", raddr, (last > 0 && c > last && c < fin) ? 64'(c - last) : 64'd0);
            check("mismatch", mismatch, exp_mis);
`endif
            pw = beat;
            if (beat) begin
                n++;
                pw_idx = n;
                pw_data = in_data;
                data[n] = in_data;
                if (n == 31) begin
                    last = c;
                    fin = c + 1 + CHK * 31;
                end
            end
            @(posedge clk); #1;
            if (c == fin) begin
                finished = 1;
                break;
            end
        end
        check("seq_finished", finished, 1);
        start = 1'b0;
        in_valid = 1'b0;
        poke = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", in_ready, 0);
        check("idle_wen", wen, 0);
`ifdef REG_LOADER_CHECK_EN
        check("hold_mismatch", mismatch, exp_mis);
`endif
        for (int i = 1; i < 32; i++)
            check($sformatf("rf[%0d]", i), rf[i], (corrupt && i == 7) ? 64'hDEAD : data[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");
        @(posedge clk); #1;
        run_seq(0, 0);
        run_seq(1, 0);
        run_seq(3, 0);
        run_seq(4, 0);
        run_seq(0, 0);
        repeat (4) run_seq(2, 0);
`ifdef REG_LOADER_CHECK_EN
        run_seq(0, 1);
        run_seq(0, 0);
        run_seq(2, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
